// File: rtl/bscan_local_mux.sv
// Multi-channel JTAG scan engine running in the buffered-TCK domain.
// Optional: define BSCAN_LOCAL_MUX_OVF_COUNT_EN to add a saturating inbound-drop counter.
module bscan_local_mux #(
  parameter int NCHAN = 4,
  parameter int WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   capture,
  input  logic                   shift,
  input  logic                   update,
  input  logic                   TDI,
  output logic                   TDO,
  input  logic [NCHAN-1:0]       toBscanEnqEna,
  input  logic [NCHAN*WIDTH-1:0] toBscanEnqV,
  output logic [NCHAN-1:0]       toBscanEnqRdy,
  output logic [NCHAN-1:0]       fromBscanEnqEna,
  output logic [NCHAN*WIDTH-1:0] fromBscanEnqV,
  input  logic [NCHAN-1:0]       fromBscanEnqRdy,
`ifdef BSCAN_LOCAL_MUX_OVF_COUNT_EN
  output logic [7:0]             ovf_count,
`endif
  output logic                   overflow
);

  localparam int CHAN_BITS = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int FRAME     = WIDTH + CHAN_BITS + 1;

  logic [NCHAN-1:0]     tx_full;
  logic [WIDTH-1:0]     tx_data [NCHAN];
  logic [NCHAN-1:0]     rx_full;
  logic [WIDTH-1:0]     rx_data [NCHAN];
  logic [FRAME-1:0]     sr;
  logic [CHAN_BITS-1:0] rr;
  logic                 cap_valid;
  logic [CHAN_BITS-1:0] cap_chan;

  logic                 arb_found;
  logic [CHAN_BITS-1:0] arb_chan;
  logic [FRAME-1:0]     cap_frame;
  logic                 upd_act;
  logic [NCHAN-1:0]     rx_deq;
  logic [NCHAN-1:0]     rx_wr;
  logic                 rx_drop;

  assign TDO             = sr[0];
  assign toBscanEnqRdy   = ~tx_full;
  assign rx_deq          = rx_full & fromBscanEnqRdy;
  assign fromBscanEnqEna = rx_deq;
  assign upd_act         = update && !capture;

  always_comb begin
    fromBscanEnqV = '0;
    for (int c = 0; c < NCHAN; c++)
      fromBscanEnqV[c*WIDTH +: WIDTH] = rx_data[c];
  end

  // Round-robin search starting at rr for the first full outbound slot.
  always_comb begin
    arb_found = 1'b0;
    arb_chan  = '0;
    for (int i = 0; i < NCHAN; i++) begin
      if (!arb_found && tx_full[(int'(rr) + i) % NCHAN]) begin
        arb_found = 1'b1;
        arb_chan  = CHAN_BITS'((int'(rr) + i) % NCHAN);
      end
    end
  end

  // An unacknowledged capture is replayed verbatim rather than re-arbitrated.
  always_comb begin
    cap_frame = '0;
`ifdef BSCAN_LOCAL_MUX_OVF_COUNT_EN
    cap_frame[WIDTH-1:0] = WIDTH'(ovf_count);
`endif
    if (cap_valid)
      cap_frame = {1'b1, cap_chan, tx_data[cap_chan]};
    else if (arb_found)
      cap_frame = {1'b1, arb_chan, tx_data[arb_chan]};
  end

  // A slot draining this cycle may be refilled; out-of-range or busy slots drop.
  always_comb begin
    rx_wr   = '0;
    rx_drop = 1'b0;
    if (upd_act && sr[FRAME-1]) begin
      rx_drop = 1'b1;
      for (int c = 0; c < NCHAN; c++) begin
        if (int'(sr[WIDTH +: CHAN_BITS]) == c && (!rx_full[c] || rx_deq[c])) begin
          rx_wr[c] = 1'b1;
          rx_drop  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      tx_full   <= '0;
      rx_full   <= '0;
      sr        <= '0;
      rr        <= '0;
      cap_valid <= 1'b0;
      cap_chan  <= '0;
      overflow  <= 1'b0;
      for (int c = 0; c < NCHAN; c++) begin
        tx_data[c] <= '0;
        rx_data[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NCHAN; c++) begin
        if (toBscanEnqEna[c] && !tx_full[c]) begin
          tx_full[c] <= 1'b1;
          tx_data[c] <= toBscanEnqV[c*WIDTH +: WIDTH];
        end
        if (rx_wr[c]) begin
          rx_full[c] <= 1'b1;
          rx_data[c] <= sr[WIDTH-1:0];
        end else if (rx_deq[c]) begin
          rx_full[c] <= 1'b0;
        end
      end

      if (capture) begin
        sr <= cap_frame;
        if (!cap_valid && arb_found) begin
          cap_valid <= 1'b1;
          cap_chan  <= arb_chan;
        end
      end else if (update) begin
        if (cap_valid) begin
          tx_full[cap_chan] <= 1'b0;
          rr                <= CHAN_BITS'((int'(cap_chan) + 1) % NCHAN);
          cap_valid         <= 1'b0;
        end
      end else if (shift) begin
        sr <= {TDI, sr[FRAME-1:1]};
      end

      if (rx_drop)
        overflow <= 1'b1;
    end
  end

`ifdef BSCAN_LOCAL_MUX_OVF_COUNT_EN
  always_ff @(posedge CLK) begin
    if (!nRST)
      ovf_count <= '0;
    else if (rx_drop && ovf_count != 8'hFF)
      ovf_count <= ovf_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_bscan_local_mux.sv
// Directed self-checking bench for bscan_local_mux with NCHAN=4, WIDTH=8.
// Covers BSCAN_LOCAL_MUX_OVF_COUNT_EN behaviour when the macro is defined.
module tb_bscan_local_mux;

  localparam int NCHAN = 4;
  localparam int WIDTH = 8;
  localparam int FRAME = 11;

  logic        clk = 1'b0;
  logic        nrst;
  logic        capture, shift, update, tdi, tdo;
  logic [3:0]  to_ena, to_rdy, from_ena, from_rdy;
  logic [31:0] to_v, from_v;
  logic        overflow;
`ifdef BSCAN_LOCAL_MUX_OVF_COUNT_EN
  logic [7:0]  ovf_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_seq [11] = '{1, 0, 1, 0, 0, 1, 0, 1, 0, 1, 1};

  bscan_local_mux #(.NCHAN(NCHAN), .WIDTH(WIDTH)) dut (
    .CLK             (clk),
    .nRST            (nrst),
    .capture         (capture),
    .shift           (shift),
    .update          (update),
    .TDI             (tdi),
    .TDO             (tdo),
    .toBscanEnqEna   (to_ena),
    .toBscanEnqV     (to_v),
    .toBscanEnqRdy   (to_rdy),
    .fromBscanEnqEna (from_ena),
    .fromBscanEnqV   (from_v),
    .fromBscanEnqRdy (from_rdy),
`ifdef BSCAN_LOCAL_MUX_OVF_COUNT_EN
    .ovf_count       (ovf_count),
`endif
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic cap, input logic upd, input logic sh, input logic din);
    capture = cap;
    update  = upd;
    shift   = sh;
    tdi     = din;
    tick();
    capture = 1'b0;
    update  = 1'b0;
    shift   = 1'b0;
    tdi     = 1'b0;
  endtask

  task automatic enq(input int ch, input logic [7:0] d);
    to_ena = 4'(1 << ch);
    to_v   = 32'(d) << (ch * 8);
    tick();
    to_ena = '0;
    to_v   = '0;
  endtask

  task automatic shift_frame(input logic v, input logic [1:0] ch, input logic [7:0] d);
    logic [10:0] f;
    f = {v, ch, d};
    for (int i = 0; i < FRAME; i++)
      applyStimulus(1'b0, 1'b0, 1'b1, f[i]);
  endtask

  task automatic capture_read(output logic [10:0] f);
    f = '0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < FRAME; i++) begin
      f[i] = tdo;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [10:0] f;
    nrst = 1'b0; capture = 1'b0; shift = 1'b0; update = 1'b0; tdi = 1'b0;
    to_ena = '0; to_v = '0; from_rdy = 4'hF;
    do_reset();
    checkOutput("reset_rdy", 32'(to_rdy), 32'hF);
    checkOutput("reset_ena", 32'(from_ena), 32'h0);
    checkOutput("reset_tdo", 32'(tdo), 32'h0);
    checkOutput("reset_ovf", 32'(overflow), 32'h0);

    // Outbound frame from ch2, LSB-first on TDO
    enq(2, 8'hA5);
    checkOutput("t1_rdy_full", 32'(to_rdy), 32'hB);
    capture_read(f);
    for (int i = 0; i < FRAME; i++)
      checkOutput($sformatf("t1_tdo%0d", i), 32'(f[i]), 32'(exp_seq[i]));
    checkOutput("t1_rdy_pre_upd", 32'(to_rdy), 32'hB);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_rdy_post_upd", 32'(to_rdy), 32'hF);

    // Inbound delivery to ch1
    shift_frame(1'b1, 2'd1, 8'h3C);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_ena", 32'(from_ena), 32'h2);
    checkOutput("t2_data", 32'(from_v[15:8]), 32'h3C);
    tick();
    checkOutput("t2_ena_clear", 32'(from_ena), 32'h0);
    checkOutput("t2_ovf", 32'(overflow), 32'h0);

    // Write into ch2 in the same cycle it drains
    from_rdy = 4'hB;
    shift_frame(1'b1, 2'd2, 8'h5A);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("wd_held", 32'(from_ena), 32'h0);
    shift_frame(1'b1, 2'd2, 8'hC3);
    from_rdy = 4'hF;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("wd_ena", 32'(from_ena), 32'h4);
    checkOutput("wd_data", 32'(from_v[23:16]), 32'hC3);
    checkOutput("wd_ovf", 32'(overflow), 32'h0);
    tick();
    checkOutput("wd_ena_clear", 32'(from_ena), 32'h0);

    // Second frame to a busy ch3 is dropped
    from_rdy = 4'h7;
    shift_frame(1'b1, 2'd3, 8'h11);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    shift_frame(1'b1, 2'd3, 8'h22);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_ovf", 32'(overflow), 32'h1);
    checkOutput("t3_data_kept", 32'(from_v[31:24]), 32'h11);
    checkOutput("t3_ena_blocked", 32'(from_ena), 32'h0);
    from_rdy = 4'hF;
    #1;
    checkOutput("t3_ena", 32'(from_ena), 32'h8);
    checkOutput("t3_data", 32'(from_v[31:24]), 32'h11);
    tick();
    checkOutput("t3_ena_once", 32'(from_ena), 32'h0);
    checkOutput("t3_ovf_sticky", 32'(overflow), 32'h1);

    // Round-robin service order
    do_reset();
    checkOutput("t4_ovf_reset", 32'(overflow), 32'h0);
    to_ena = 4'hB;
    to_v   = 32'h13_00_11_10;
    tick();
    to_ena = '0;
    to_v   = '0;
    capture_read(f);
    checkOutput("t4_frame1", 32'(f), 32'h410);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    capture_read(f);
    checkOutput("t4_frame2", 32'(f), 32'h511);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    capture_read(f);
    checkOutput("t4_frame3", 32'(f), 32'h713);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    capture_read(f);
    checkOutput("t4_idle", 32'(f), 32'h000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    enq(0, 8'h55);
    capture_read(f);
    checkOutput("t4_refill", 32'(f), 32'h455);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);

    // Capture without update replays the same channel
    enq(1, 8'h77);
    capture_read(f);
    checkOutput("t5_first", 32'(f), 32'h577);
    capture_read(f);
    checkOutput("t5_replay", 32'(f), 32'h577);
    checkOutput("t5_rdy_busy", 32'(to_rdy), 32'hD);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_rdy_free", 32'(to_rdy), 32'hF);

    // Reset mid-shift drops the pending capture and the sticky flag
    from_rdy = 4'hE;
    shift_frame(1'b1, 2'd0, 8'hAA);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_ovf_set", 32'(overflow), 32'h1);
    from_rdy = 4'hF;
    enq(2, 8'h99);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    checkOutput("t6_rdy", 32'(to_rdy), 32'hF);
    checkOutput("t6_tdo", 32'(tdo), 32'h0);
    checkOutput("t6_ovf", 32'(overflow), 32'h0);
    checkOutput("t6_ena", 32'(from_ena), 32'h0);
    capture_read(f);
    checkOutput("t6_lost", 32'(f), 32'h000);

`ifdef BSCAN_LOCAL_MUX_OVF_COUNT_EN
    // Saturating drop counter visible in the idle frame
    do_reset();
    checkOutput("oc_reset", 32'(ovf_count), 32'h0);
    from_rdy = 4'hE;
    shift_frame(1'b1, 2'd0, 8'h01);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("oc_one", 32'(ovf_count), 32'h1);
    for (int i = 1; i < 300; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("oc_sat", 32'(ovf_count), 32'hFF);
    checkOutput("oc_ovf", 32'(overflow), 32'h1);
    capture_read(f);
    checkOutput("oc_idle_frame", 32'(f), 32'h0FF);
    from_rdy = 4'hF;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
